// File: rtl/sc_ifu.sv
// sc_ifu: instruction fetch/issue unit.
// Owns the architectural PC. Fetches one word at a time from imem over a
// req/ack handshake, holds it in a single instruction register (IR) until
// the datapath retires it, then computes the next PC from the control unit's
// pcsource selection. There is no prefetch and no buffering beyond the IR.
module sc_ifu #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [11:0]       op,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              retire,
    input  logic [1:0]        pcsource,
    input  logic [ADDR_W-1:0] reg_target
);

    // FETCH_WAIT is the post-reset idle state; it always moves to FETCH.
    typedef enum logic [1:0] {
        FETCH_WAIT = 2'd0,
        FETCH      = 2'd1,
        ISSUE      = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_valid;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_pc;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_offset;
    logic [ADDR_W-1:0] w_next_pc;

    // PC+4 and the sign-extended, word-scaled branch offset; adds wrap mod 2^32.
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_br_offset = {{(ADDR_W-18){r_inst[15]}}, r_inst[15:0], 2'b00};

    // Next-PC selection; only consumed when retire is taken in ISSUE.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pcsource)
            2'b00:   w_next_pc = w_pc_plus4;
            2'b01:   w_next_pc = w_pc_plus4 + w_br_offset;
            2'b10:   w_next_pc = reg_target & ~ADDR_W'(3);
            2'b11:   w_next_pc = {w_pc_plus4[ADDR_W-1:ADDR_W-4], r_inst[25:0], 2'b00};
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Fetch/issue FSM with registered request, valid, IR and PC.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= FETCH_WAIT;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_inst  <= 32'h0;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                FETCH_WAIT: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    // Request stays high with a stable address until ack.
                    if (imem_ack) begin
                        r_inst  <= imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The IR is held; a stray ack here is ignored.
                    if (retire) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH_WAIT;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign op         = {r_inst[31:26], r_inst[5:0]};
    assign inst_valid = r_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;

endmodule

// File: tb/tb_sc_ifu.sv
// Testbench for sc_ifu: directed steps followed by a randomized run, all
// checked against a transaction-level model of the fetch/issue protocol.
module tb_sc_ifu;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [11:0] op;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [1:0]  pcsource;
    logic [31:0] reg_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether a fetch is outstanding, whether the IR holds a
    // live instruction, the architectural PC and the IR contents.
    bit          m_fetching;
    bit          m_holding;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    sc_ifu #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .op         (op),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .retire     (retire),
        .pcsource   (pcsource),
        .reg_target (reg_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule written as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] cur_pc,
                                               input logic [31:0] ir, input logic [31:0] tgt);
        logic [31:0] p4;
        int          off;
        p4  = cur_pc + 32'd4;
        off = 32'($signed(ir[15:0]));
        case (sel)
            2'b00:   return p4;
            2'b01:   return p4 + 32'(off * 4);
            2'b10:   return tgt & 32'hFFFF_FFFC;
            default: return (p4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
        endcase
    endfunction

    // Compare every DUT output against the model.
    task automatic check_all();
        chk("imem_req",   {31'b0, imem_req},   {31'b0, m_fetching});
        chk("imem_addr",  imem_addr,           m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_holding});
        chk("pc",         pc,                  m_pc);
        chk("pc_plus4",   pc_plus4,            m_pc + 32'd4);
        chk("inst",       inst,                m_ir);
        chk("op",         {20'b0, op},         {20'b0, m_ir[31:26], m_ir[5:0]});
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then sample DUT outputs 1 time unit after the edge.
    task automatic tick();
        if (!resetn) begin
            m_fetching = 1'b0;
            m_holding  = 1'b0;
            m_pc       = RST_PC;
            m_ir       = 32'h0;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_ir       = imem_rdata;
                m_fetching = 1'b0;
                m_holding  = 1'b1;
            end
        end else if (m_holding) begin
            if (retire) begin
                m_pc       = model_next(pcsource, m_pc, m_ir, reg_target);
                m_holding  = 1'b0;
                m_fetching = 1'b1;
            end
        end else begin
            m_fetching = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Complete a fetch on the first request cycle with the given word.
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Retire the instruction in the IR with the given selection.
    task automatic retire_with(input logic [1:0] sel, input logic [31:0] tgt);
        retire     = 1'b1;
        pcsource   = sel;
        reg_target = tgt;
        tick();
        retire     = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        retire     = 1'b0;
        pcsource   = 2'b00;
        reg_target = 32'h0;
        m_fetching = 1'b0;
        m_holding  = 1'b0;
        m_pc       = RST_PC;
        m_ir       = 32'h0;

        // Reset held 3 clocks with imem_ack toggling.
        for (int i = 0; i < 3; i++) begin
            imem_ack = ~imem_ack;
            tick();
        end
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc",    pc,                  32'h0);
        chk("rst_inst",  inst,                32'h0);

        // Release: request still low in the first cycle, raised after one edge.
        resetn   = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("rel_req0", {31'b0, imem_req}, 32'd0);
        tick();
        chk("rel_req1", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // Sequential fetch at two cycles per instruction.
        fetch(32'h0000_0001);
        chk("seq_op",    {20'b0, op},         32'h001);
        chk("seq_valid", {31'b0, inst_valid}, 32'd1);
        chk("seq_req",   {31'b0, imem_req},   32'd0);
        retire_with(2'b00, 32'h0);
        chk("seq_addr4", imem_addr, 32'h4);
        fetch(32'h1234_5678);
        retire_with(2'b00, 32'h0);
        chk("seq_addr8", imem_addr, 32'h8);

        // Delayed ack with retire pulses during FETCH.
        retire   = 1'b1;
        pcsource = 2'b10;
        reg_target = 32'h0000_4444;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dly_req",  {31'b0, imem_req}, 32'd1);
            chk("dly_addr", imem_addr, 32'h8);
        end
        retire = 1'b0;

        // A late ack arriving during ISSUE must not overwrite the IR.
        fetch(32'hAAAA_0001);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        tick();
        imem_ack   = 1'b0;
        chk("issue_ack_ir", inst, 32'hAAAA_0001);

        // Branch back by two words from 0x100, then forward by three words.
        retire_with(2'b10, 32'h0000_0100);
        chk("br_base", imem_addr, 32'h100);
        fetch(32'h1000_FFFE);
        retire_with(2'b01, 32'h0);
        chk("br_neg", imem_addr, 32'h0000_00FC);
        fetch(32'h0);
        retire_with(2'b10, 32'h0000_0100);
        fetch(32'h1000_0003);
        retire_with(2'b01, 32'h0);
        chk("br_pos", imem_addr, 32'h0000_0110);

        // Jump and register-indirect targets.
        fetch(32'h0);
        retire_with(2'b10, 32'h1000_0000);
        fetch(32'h0800_0040);
        retire_with(2'b11, 32'h0);
        chk("jump", imem_addr, 32'h1000_0100);
        fetch(32'h0);
        retire_with(2'b10, 32'h0000_2003);
        chk("jr_mask", imem_addr, 32'h0000_2000);

        // PC wrap at the top of the address space.
        fetch(32'h0);
        retire_with(2'b10, 32'hFFFF_FFFC);
        fetch(32'h0);
        retire_with(2'b00, 32'h0);
        chk("wrap", imem_addr, 32'h0);

        // Reset during ISSUE together with retire: reset wins.
        fetch(32'h0);
        retire_with(2'b10, 32'h0000_0800);
        fetch(32'hCAFE_F00D);
        resetn = 1'b0;
        retire_with(2'b10, 32'h0000_0500);
        chk("rst_iss_pc",    pc,                  RST_PC);
        chk("rst_iss_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_iss_req",   {31'b0, imem_req},   32'd0);
        resetn = 1'b1;

        // Randomized protocol traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            resetn     = ($urandom_range(0, 63) != 0);
            imem_ack   = $urandom_range(0, 1) == 1;
            imem_rdata = $urandom;
            retire     = $urandom_range(0, 1) == 1;
            pcsource   = 2'($urandom_range(0, 3));
            reg_target = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_ifu.md
Name: sc_ifu

Overview:
- Instruction fetch/issue unit: the producing end of the control-unit interface.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake and presents the 12-bit op field {inst[31:26], inst[5:0]} plus the full word to the control unit and datapath.
- Consumes the control unit's 2-bit pcsource selection when the datapath retires the instruction, then computes the next PC.
- Sits between imem and the control-unit/datapath pair; it alone owns the architectural PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
ADDR_W, 32, PC / imem address width; fixed at 32 for this core.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  synchronous active-low reset; sampled on rising clk.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  32  fetch address = current PC; stable while imem_req=1.
imem_ack  in  1  imem_rdata valid this cycle; ends the fetch.
imem_rdata  in  32  instruction word.
inst  out  32  instruction register (IR).
op  out  12  {inst[31:26], inst[5:0]}, to control unit.
inst_valid  out  1  IR holds an instruction awaiting retire.
pc  out  32  PC of the instruction in IR.
pc_plus4  out  32  pc + 4 (link value, branch base).
retire  in  1  datapath completes the current instruction; pcsource valid this cycle.
pcsource  in  2  next-PC select from control unit.
reg_target  in  32  register jump target for pcsource=10.

Behaviour:
- Reset (resetn=0 at rising edge): state<=FETCH_WAIT, pc<=RESET_PC, inst<=0, inst_valid<=0, imem_req<=0. Reset asserted mid-fetch or mid-issue abandons that instruction; an imem_ack arriving in the reset cycle is ignored.
- State machine, 3 states:
  - IDLE: entered only from reset (FETCH_WAIT acts as IDLE). Next cycle goes to FETCH with imem_req=1.
  - FETCH: imem_req=1, imem_addr=pc, inst_valid=0. On imem_ack=1: inst<=imem_rdata, state<=ISSUE. An ack in the first FETCH cycle is legal.
  - ISSUE: imem_req=0, inst_valid=1, op/inst stable. On retire=1: pc<=next_pc, inst_valid<=0, state<=FETCH.
- Minimum throughput: 2 cycles per instruction (ack in the first FETCH cycle, retire in the first ISSUE cycle).
- imem_req/imem_addr: registered outputs. imem_req drops in the cycle after ack is sampled.
- next_pc by pcsource, sampled only when retire=1 in ISSUE:
  - 00: pc+4.
  - 01: pc+4 + {{14{inst[15]}}, inst[15:0], 2'b00} (taken beq/bne).
  - 10: {reg_target[31:2], 2'b00} (low bits forced to zero).
  - 11: {pc_plus4[31:28], inst[25:0], 2'b00} (jump).
- Arithmetic: all adds are modulo 2^32, so wrap is silent. pc=32'hFFFF_FFFC with pcsource 00 gives next_pc=0. A negative offset below 0 wraps to the top of the address space.
- Ignored inputs:
  - retire outside ISSUE is ignored; pcsource and reg_target are don't-care then.
  - imem_ack outside FETCH is ignored; the IR is not overwritten.
- op/pc/pc_plus4 are combinational from the IR and PC registers; no extra latency.
- Simultaneous events:
  - resetn=0 with retire=1: reset wins.
  - resetn=0 with imem_ack=1: reset wins.
- Design size: no buffering beyond the single IR; no prefetch.

Test Plan:
- Reset: hold resetn=0 for 3 clocks with imem_ack=1 toggling -> imem_req=0, inst_valid=0, pc=0. First cycle after release: imem_req=0. Second cycle: imem_req=1, imem_addr=0.
- Sequential fetch: ack on the first request cycle with rdata=32'h0000_0001 -> op=12'h001, inst_valid next cycle. Retire with pcsource=00 -> next imem_addr=4. Repeat to 8 at 2 cycles per instruction.
- Delayed ack: hold ack low for 5 cycles -> imem_req and imem_addr stay constant. Retire pulses during FETCH do not change pc.
- Branch: pc=0x100, inst[15:0]=16'hFFFE, retire with pcsource=01 -> next addr 0x100+4-8=0xFC. With inst[15:0]=0x0003 -> 0x110.
- Jump/register: pc=0x1000_0000, inst[25:0]=26'h0000040, pcsource=11 -> addr 0x1000_0100. pcsource=10 with reg_target=0x0000_2003 -> addr 0x0000_2000.
- Wrap and reset mid-op: pc=0xFFFF_FFFC, pcsource=00 -> addr 0. Assert resetn=0 during ISSUE with retire=1 -> pc=RESET_PC, inst_valid=0, retire has no effect.
